// File: rtl/jala_fetch_pkg.sv
// Shared types and constants for the jala instruction-fetch stage.
package jala_fetch_pkg;

  localparam int PC_W = 16;

  localparam logic [PC_W-1:0] FETCH_NOP = 16'h0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/jala_pc_next.sv
// Combinational next-PC select: absolute target, relative offset or sequential step.
module jala_pc_next
  import jala_fetch_pkg::*;
#(
  parameter int PC_INC = 2
) (
  input  logic [PC_W-1:0] pc,
  input  logic            pc_source,
  input  logic            pc_add,
  input  logic [PC_W-1:0] pc_target,
  input  logic [PC_W-1:0] pc_offset,
  output logic [PC_W-1:0] pc_next
);

  // Sums wrap modulo 2^16; a negative offset is just its two's-complement pattern.
  always_comb begin
    pc_next = pc + PC_W'(PC_INC);
    if (pc_source) begin
      pc_next = pc_target;
    end else if (pc_add) begin
      pc_next = pc + pc_offset;
    end
  end

endmodule

// File: rtl/jala_fetch_unit.sv
// Instruction-fetch stage: PC register, IR, and req/ack handshake with instruction memory.
// Optional ack-wait timeout enabled by defining FETCH_TIMEOUT_EN.
//
// state      | meaning
// FETCH_IDLE | no fetch in flight, waiting for IRWrite
// FETCH_REQ  | IMemReq held, waiting for IMemAck (or timeout)
// FETCH_DONE | IROut freshly loaded, IRValid high this cycle
module jala_fetch_unit
  import jala_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_INC   = 2,
  parameter int          TIMEOUT  = 15
) (
  input  logic        CLK,
  input  logic        CtrlRst,
  input  logic        PCWrite,
  input  logic        PCSource,
  input  logic        PCAdd,
  input  logic [15:0] PCTarget,
  input  logic [15:0] PCOffset,
  input  logic        IRWrite,
  input  logic [15:0] IMemData,
  input  logic        IMemAck,
  output logic        IMemReq,
  output logic [15:0] IMemAddr,
  output logic [15:0] PC,
  output logic [15:0] IROut,
  output logic        IRValid,
  output logic        FetchBusy,
  output logic        FetchOverrun,
  output logic        FetchFault
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_nxt;
  logic [PC_W-1:0] imem_addr_q, imem_addr_d;
  logic [PC_W-1:0] ir_q, ir_d;
  logic            imem_req_q, imem_req_d;
  logic            ir_valid_q, ir_valid_d;
  logic            overrun_q, overrun_d;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       fault_q, fault_d;
`else
  wire unused_timeout = |TIMEOUT;
`endif

  jala_pc_next #(
    .PC_INC(PC_INC)
  ) u_pc_next (
    .pc       (pc_q),
    .pc_source(PCSource),
    .pc_add   (PCAdd),
    .pc_target(PCTarget),
    .pc_offset(PCOffset),
    .pc_next  (pc_nxt)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = PCWrite ? pc_nxt : pc_q;
    imem_addr_d = imem_addr_q;
    imem_req_d  = imem_req_q;
    ir_d        = ir_q;
    ir_valid_d  = 1'b0;
    overrun_d   = overrun_q;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    fault_d     = fault_q;
`endif
    case (state_q)
      FETCH_IDLE, FETCH_DONE: begin
        state_d = FETCH_IDLE;
        // Address is the PC before any same-cycle PCWrite takes effect.
        if (IRWrite) begin
          imem_addr_d = pc_q;
          imem_req_d  = 1'b1;
          state_d     = FETCH_REQ;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt_d  = 4'd0;
`endif
        end
      end
      FETCH_REQ: begin
        if (IRWrite) begin
          overrun_d = 1'b1;
        end
        if (IMemAck) begin
          ir_d       = IMemData;
          imem_req_d = 1'b0;
          ir_valid_d = 1'b1;
          state_d    = FETCH_DONE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          ir_d       = FETCH_NOP;
          fault_d    = 1'b1;
          imem_req_d = 1'b0;
          ir_valid_d = 1'b1;
          state_d    = FETCH_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
`endif
      end
      default: begin
        state_d    = FETCH_IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CtrlRst) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= RESET_PC;
      imem_addr_q <= '0;
      imem_req_q  <= 1'b0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q  <= 4'd0;
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_addr_q <= imem_addr_d;
      imem_req_q  <= imem_req_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      overrun_q   <= overrun_d;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      fault_q     <= fault_d;
`endif
    end
  end

  assign IMemReq      = imem_req_q;
  assign IMemAddr     = imem_addr_q;
  assign PC           = pc_q;
  assign IROut        = ir_q;
  assign IRValid      = ir_valid_q;
  assign FetchBusy    = (state_q == FETCH_REQ);
  assign FetchOverrun = overrun_q;
`ifdef FETCH_TIMEOUT_EN
  assign FetchFault   = fault_q;
`else
  assign FetchFault   = 1'b0;
`endif

endmodule

// File: tb/tb_jala_fetch_unit.sv
// Directed self-checking bench for jala_fetch_unit (timeout scenarios when FETCH_TIMEOUT_EN is defined).
module tb_jala_fetch_unit;

  logic        CLK = 1'b0;
  logic        CtrlRst, PCWrite, PCSource, PCAdd, IRWrite, IMemAck;
  logic [15:0] PCTarget, PCOffset, IMemData;
  logic        IMemReq, IRValid, FetchBusy, FetchOverrun, FetchFault;
  logic [15:0] IMemAddr, PC, IROut;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  jala_fetch_unit dut (
    .CLK(CLK), .CtrlRst(CtrlRst), .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
    .PCTarget(PCTarget), .PCOffset(PCOffset), .IRWrite(IRWrite), .IMemData(IMemData),
    .IMemAck(IMemAck), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .PC(PC), .IROut(IROut),
    .IRValid(IRValid), .FetchBusy(FetchBusy), .FetchOverrun(FetchOverrun), .FetchFault(FetchFault)
  );

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    CtrlRst = 1'b0;
    cyc(); cyc();
    checks++; if (PC !== 16'h0000) begin failures++; $display("FAIL rst_pc got=%h exp=0000", PC); end
    checks++; if (IROut !== 16'h0000) begin failures++; $display("FAIL rst_ir got=%h exp=0000", IROut); end
    checks++; if ({IMemReq, IRValid, FetchBusy, FetchOverrun, FetchFault} !== 5'b0) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {IMemReq, IRValid, FetchBusy, FetchOverrun, FetchFault}); end
    checks++; if (IMemAddr !== 16'h0000) begin failures++; $display("FAIL rst_addr got=%h exp=0000", IMemAddr); end
    CtrlRst = 1'b1;
    cyc();
  endtask

  task automatic test_basic_fetch();
    IRWrite = 1'b1;
    cyc();
    IRWrite = 1'b0;
    checks++; if (IMemReq !== 1'b1 || FetchBusy !== 1'b1) begin failures++; $display("FAIL basic_req got=%b%b exp=11", IMemReq, FetchBusy); end
    checks++; if (IMemAddr !== 16'h0000) begin failures++; $display("FAIL basic_addr got=%h exp=0000", IMemAddr); end
    cyc(); cyc();
    checks++; if (IMemReq !== 1'b1 || IMemAddr !== 16'h0000 || IRValid !== 1'b0) begin failures++; $display("FAIL basic_hold got=%b/%h/%b exp=1/0000/0", IMemReq, IMemAddr, IRValid); end
    IMemAck = 1'b1; IMemData = 16'h8005;
    cyc();
    IMemAck = 1'b0;
    checks++; if (IROut !== 16'h8005 || IRValid !== 1'b1) begin failures++; $display("FAIL basic_load got=%h/%b exp=8005/1", IROut, IRValid); end
    checks++; if (IMemReq !== 1'b0 || FetchBusy !== 1'b0) begin failures++; $display("FAIL basic_drop got=%b%b exp=00", IMemReq, FetchBusy); end
    cyc();
    checks++; if (IRValid !== 1'b0 || IROut !== 16'h8005) begin failures++; $display("FAIL basic_pulse got=%b/%h exp=0/8005", IRValid, IROut); end
    checks++; if (PC !== 16'h0000) begin failures++; $display("FAIL basic_pc got=%h exp=0000", PC); end
  endtask

  task automatic test_pc_next();
    PCWrite = 1'b1; PCSource = 1'b1; PCAdd = 1'b0; PCTarget = 16'hFFFE;
    cyc();
    checks++; if (PC !== 16'hFFFE) begin failures++; $display("FAIL pc_target1 got=%h exp=FFFE", PC); end
    PCSource = 1'b0;
    cyc();
    checks++; if (PC !== 16'h0000) begin failures++; $display("FAIL pc_inc_wrap got=%h exp=0000", PC); end
    PCSource = 1'b1; PCTarget = 16'h0010;
    cyc();
    PCSource = 1'b0; PCAdd = 1'b1; PCOffset = 16'hFFFC;
    cyc();
    checks++; if (PC !== 16'h000C) begin failures++; $display("FAIL pc_offset got=%h exp=000C", PC); end
    PCSource = 1'b1; PCAdd = 1'b0; PCTarget = 16'h0004;
    cyc();
    PCSource = 1'b0; PCAdd = 1'b1;
    cyc();
    checks++; if (PC !== 16'h0000) begin failures++; $display("FAIL pc_offset_wrap got=%h exp=0000", PC); end
    PCSource = 1'b1; PCAdd = 1'b0; PCTarget = 16'h1234;
    cyc();
    PCWrite = 1'b0; PCTarget = 16'h5555;
    checks++; if (PC !== 16'h1234) begin failures++; $display("FAIL pc_target2 got=%h exp=1234", PC); end
    cyc();
    checks++; if (PC !== 16'h1234) begin failures++; $display("FAIL pc_hold got=%h exp=1234", PC); end
    PCSource = 1'b0;
  endtask

  task automatic test_same_cycle();
    PCWrite = 1'b1; PCSource = 1'b1; PCTarget = 16'h0040;
    cyc();
    PCSource = 1'b0; PCAdd = 1'b0; IRWrite = 1'b1;
    cyc();
    IRWrite = 1'b0;
    checks++; if (IMemAddr !== 16'h0040 || PC !== 16'h0042) begin failures++; $display("FAIL same_addr_pc got=%h/%h exp=0040/0042", IMemAddr, PC); end
    cyc();
    PCWrite = 1'b0;
    checks++; if (PC !== 16'h0044 || IMemAddr !== 16'h0040 || IMemReq !== 1'b1) begin failures++; $display("FAIL req_pcwrite got=%h/%h/%b exp=0044/0040/1", PC, IMemAddr, IMemReq); end
    IMemAck = 1'b1; IMemData = 16'h1111;
    cyc();
    IMemAck = 1'b0;
    checks++; if (IROut !== 16'h1111 || IRValid !== 1'b1) begin failures++; $display("FAIL same_load got=%h/%b exp=1111/1", IROut, IRValid); end
    cyc();
  endtask

  task automatic test_back_to_back();
    IRWrite = 1'b1;
    cyc();
    IRWrite = 1'b0; IMemAck = 1'b1; IMemData = 16'h3333;
    cyc();
    IMemAck = 1'b0;
    checks++; if (IROut !== 16'h3333 || IRValid !== 1'b1) begin failures++; $display("FAIL b2b_first got=%h/%b exp=3333/1", IROut, IRValid); end
    IRWrite = 1'b1;
    cyc();
    IRWrite = 1'b0;
    checks++; if (IMemReq !== 1'b1 || FetchBusy !== 1'b1 || IRValid !== 1'b0 || IMemAddr !== 16'h0044) begin failures++; $display("FAIL b2b_restart got=%b%b%b/%h exp=110/0044", IMemReq, FetchBusy, IRValid, IMemAddr); end
    checks++; if (FetchOverrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b exp=0", FetchOverrun); end
    IMemAck = 1'b1; IMemData = 16'h4444;
    cyc();
    IMemAck = 1'b0;
    checks++; if (IROut !== 16'h4444 || IRValid !== 1'b1) begin failures++; $display("FAIL b2b_second got=%h/%b exp=4444/1", IROut, IRValid); end
    cyc();
  endtask

  task automatic test_overrun();
    int vcnt;
    IRWrite = 1'b1;
    cyc();
    cyc();
    IRWrite = 1'b0;
    checks++; if (FetchOverrun !== 1'b1 || IMemReq !== 1'b1 || IMemAddr !== 16'h0044) begin failures++; $display("FAIL ovr_set got=%b%b/%h exp=11/0044", FetchOverrun, IMemReq, IMemAddr); end
    IMemAck = 1'b1; IMemData = 16'h2222;
    cyc();
    IMemAck = 1'b0;
    vcnt = int'(IRValid);
    for (int i = 0; i < 4; i++) begin
      cyc();
      vcnt += int'(IRValid);
    end
    checks++; if (vcnt !== 1) begin failures++; $display("FAIL ovr_valid_count got=%0d exp=1", vcnt); end
    IMemAck = 1'b1; IMemData = 16'hBEEF;
    cyc();
    IMemAck = 1'b0;
    checks++; if (IROut !== 16'h2222 || IMemReq !== 1'b0 || FetchBusy !== 1'b0 || IRValid !== 1'b0) begin failures++; $display("FAIL spurious_ack got=%h/%b%b%b exp=2222/000", IROut, IMemReq, FetchBusy, IRValid); end
    checks++; if (FetchOverrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", FetchOverrun); end
  endtask

  task automatic test_reset_mid_fetch();
    IRWrite = 1'b1;
    cyc();
    IRWrite = 1'b0; CtrlRst = 1'b0;
    cyc();
    CtrlRst = 1'b1; IMemAck = 1'b1; IMemData = 16'h5555;
    cyc();
    IMemAck = 1'b0;
    checks++; if (PC !== 16'h0000 || IROut !== 16'h0000 || IMemAddr !== 16'h0000) begin failures++; $display("FAIL mid_rst_regs got=%h/%h/%h exp=0000/0000/0000", PC, IROut, IMemAddr); end
    checks++; if ({IMemReq, IRValid, FetchBusy, FetchOverrun, FetchFault} !== 5'b0) begin failures++; $display("FAIL mid_rst_flags got=%b exp=00000", {IMemReq, IRValid, FetchBusy, FetchOverrun, FetchFault}); end
    cyc();
    checks++; if (IRValid !== 1'b0 || IROut !== 16'h0000) begin failures++; $display("FAIL mid_rst_late_ack got=%b/%h exp=0/0000", IRValid, IROut); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    IRWrite = 1'b1;
    cyc();
    IRWrite = 1'b0; IMemAck = 1'b1; IMemData = 16'hABCD;
    cyc();
    IMemAck = 1'b0;
    cyc();
    IRWrite = 1'b1;
    cyc();
    IRWrite = 1'b0;
    repeat (14) cyc();
    checks++; if (IMemReq !== 1'b1 || FetchFault !== 1'b0 || IROut !== 16'hABCD) begin failures++; $display("FAIL to_before got=%b%b/%h exp=10/ABCD", IMemReq, FetchFault, IROut); end
    cyc();
    checks++; if (FetchFault !== 1'b1 || IROut !== 16'h0000 || IRValid !== 1'b1 || IMemReq !== 1'b0) begin failures++; $display("FAIL to_fire got=%b/%h/%b%b exp=1/0000/10", FetchFault, IROut, IRValid, IMemReq); end
    cyc();
    checks++; if (IRValid !== 1'b0 || FetchFault !== 1'b1) begin failures++; $display("FAIL to_sticky got=%b%b exp=01", IRValid, FetchFault); end
    CtrlRst = 1'b0;
    cyc();
    CtrlRst = 1'b1; IRWrite = 1'b1;
    cyc();
    IRWrite = 1'b0;
    repeat (14) cyc();
    IMemAck = 1'b1; IMemData = 16'h6789;
    cyc();
    IMemAck = 1'b0;
    checks++; if (IROut !== 16'h6789 || FetchFault !== 1'b0 || IRValid !== 1'b1) begin failures++; $display("FAIL to_ack_wins got=%h/%b%b exp=6789/01", IROut, FetchFault, IRValid); end
    cyc();
  endtask
`else
  task automatic test_timeout();
    IRWrite = 1'b1;
    cyc();
    IRWrite = 1'b0;
    repeat (20) cyc();
    checks++; if (IMemReq !== 1'b1 || FetchBusy !== 1'b1 || FetchFault !== 1'b0) begin failures++; $display("FAIL no_to_wait got=%b%b%b exp=110", IMemReq, FetchBusy, FetchFault); end
    IMemAck = 1'b1; IMemData = 16'h6789;
    cyc();
    IMemAck = 1'b0;
    checks++; if (IROut !== 16'h6789 || IRValid !== 1'b1 || FetchFault !== 1'b0) begin failures++; $display("FAIL no_to_load got=%h/%b%b exp=6789/10", IROut, IRValid, FetchFault); end
    cyc();
  endtask
`endif

  initial begin
    CtrlRst = 1'b0; PCWrite = 1'b0; PCSource = 1'b0; PCAdd = 1'b0;
    PCTarget = 16'h0000; PCOffset = 16'h0000; IRWrite = 1'b0;
    IMemData = 16'h0000; IMemAck = 1'b0;
    test_reset();
    test_basic_fetch();
    test_pc_next();
    test_same_cycle();
    test_back_to_back();
    test_overrun();
    test_reset_mid_fetch();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jala_fetch_unit.md
Name: jala_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the stage-4 decode/control integration block; sole producer of the IROut bus that stage decodes.
- Holds the program counter (PC) and instruction register (IR).
- Computes next-PC from the control strobes stage 4 emits: PCWrite, PCSource, PCAdd.
- On IRWrite, runs a req/ack handshake with instruction memory.
- Reports FetchBusy so the controller can stall.

Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- PC_INC, 2: sequential PC increment, in bytes.
- TIMEOUT, 15: ack-wait limit in cycles; used only with FETCH_TIMEOUT_EN.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- CtrlRst  input  1  synchronous active-low reset.
- PCWrite  input  1  update PC this cycle.
- PCSource  input  1  1 = load PCTarget; 0 = arithmetic next-PC.
- PCAdd  input  1  with PCSource=0: 1 = PC+PCOffset, 0 = PC+PC_INC.
- PCTarget  input  16  absolute jump target (ALU result).
- PCOffset  input  16  signed relative offset (stage-4 SignExtOut).
- IRWrite  input  1  start instruction fetch at current PC.
- IMemData  input  16  instruction word from memory.
- IMemAck  input  1  memory data valid, single-cycle pulse.
- IMemReq  output  1  fetch request.
- IMemAddr  output  16  fetch address.
- PC  output  16  current program counter.
- IROut  output  16  instruction register, to stage 4.
- IRValid  output  1  one-cycle pulse: IROut newly loaded.
- FetchBusy  output  1  fetch in flight.
- FetchOverrun  output  1  sticky: IRWrite arrived while busy.
- FetchFault  output  1  sticky timeout flag; constant 0 when FETCH_TIMEOUT_EN is undefined.

Behaviour:
- Reset, CtrlRst=0 sampled at a rising edge:
  - PC = RESET_PC; IROut = 16'h0000; state IDLE.
  - IMemReq, IMemAddr, IRValid, FetchBusy, FetchOverrun, FetchFault all 0.
  - Reset mid-fetch abandons the request; a late IMemAck after reset is ignored.
- Next-PC, applied only when PCWrite=1:
  - PCSource=1: PCTarget.
  - else PCAdd=1: PC+PCOffset.
  - else: PC+PC_INC.
  - All sums are 16-bit modulo (FFFE+2 = 0000; 0004+FFFC = 0000).
  - PCWrite is honoured in every FSM state.
- FSM, 3 states:
  - IDLE: on IRWrite, latch IMemAddr = PC as it stands that cycle (the pre-update value if PCWrite is also high), drive IMemReq=1, go to REQ.
  - REQ: hold IMemReq=1 and IMemAddr stable until IMemAck. On ack: IROut = IMemData, IMemReq=0, go to DONE.
  - DONE: IRValid=1 for exactly this cycle, then IDLE. IRWrite in DONE is accepted as a new fetch (DONE → REQ), back-to-back.
- FetchBusy = 1 in REQ only.
- Latency: IRWrite at edge n → IMemReq visible after edge n. Ack sampled at edge m → IROut updated and IRValid high after edge m. Minimum IRWrite→IRValid is 2 cycles.
- IRWrite while in REQ: ignored, and sets FetchOverrun, which is cleared only by reset.
- IMemAck outside REQ: ignored.
- IROut holds its value between fetches.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A 4-bit wait counter clears on entry to REQ and increments each REQ cycle without ack.
  - Reaching TIMEOUT without ack: IROut = FETCH_NOP (16'h0000), set sticky FetchFault, drop IMemReq, go to DONE so IRValid still pulses.
  - An ack in the same cycle the counter reaches TIMEOUT wins: normal load, no fault.
- Undefined: no counter; REQ waits indefinitely; FetchFault tied 0.

Decomposition:
- Package jala_fetch_pkg:
  - state enum FETCH_IDLE/FETCH_REQ/FETCH_DONE;
  - FETCH_NOP constant;
  - PC width constant (16).
- Sub-module jala_pc_next: combinational next-PC mux/adder (PC, PCSource, PCAdd, PCTarget, PCOffset → next PC). Instantiated once; the PC register stays in the top.

Test Plan:
- Reset then IRWrite, memory acks 3 cycles later with 16'h8005 → IMemAddr=0000 while req held; IROut=8005; IRValid high exactly one cycle; PC unchanged at 0000.
- PCWrite, PCSource=0, PCAdd=0 from PC=FFFE → PC=0000 (wrap). PCAdd=1, PCOffset=FFFC from PC=0010 → PC=000C. PCSource=1, PCTarget=1234 → PC=1234.
- IRWrite and PCWrite same cycle, PC=0040 → IMemAddr=0040; PC becomes 0042.
- Second IRWrite during REQ → ignored; FetchOverrun=1; exactly one IRValid; spurious IMemAck in IDLE leaves IROut unchanged.
- CtrlRst low during REQ, ack arrives next cycle → all outputs at reset values; IROut stays 0000.
- FETCH_TIMEOUT_EN defined, never ack → after 15 REQ cycles: FetchFault=1, IROut=0000, IRValid pulses. Ack on cycle 15 → loads data, FetchFault stays 0.
